// File: rtl/data_mem_resp.sv
// data_mem_resp
// Data-port responder for a single-cycle CPU. It decodes each word access
// (address bits [1:0] are ignored) into one of these targets:
//   - a word RAM at byte addresses [0, 4*RAM_WORDS);
//   - four MMIO registers starting at MMIO_BASE:
//       +0 LED     (read/write, bits [7:0])
//       +4 CYCCNT  (read/write)
//       +8 STCNT   (read only)
//       +C ERRSTAT (read/write)
// Loads are combinational. A store takes effect at the rising edge of the
// cycle in which it is presented.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   MemWrite    store strobe; one store per asserted cycle
//   Mem_WrAddr  byte address for loads and stores
//   Mem_WrData  store data
//   ReadData    load data (zero latency)
//   leds        LED register
//   err         sticky flag, set by a store to an unmapped address

module data_mem_resp #(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        err
);

  localparam int unsigned AW     = $clog2(RAM_WORDS);
  localparam logic [31:0] BASE_W = {MMIO_BASE[31:2], 2'b00};

  // Word-aligned view of the address; the byte-lane bits play no role.
  logic [31:0] addr_w;
  logic        unused_addr_lsbs;
  assign addr_w           = {Mem_WrAddr[31:2], 2'b00};
  assign unused_addr_lsbs = ^Mem_WrAddr[1:0];

  // Address decode. RAM requires every bit above the index to be zero, so
  // addresses past the end of the RAM can never fold back onto a RAM word.
  logic hit_ram, hit_led, hit_cyc, hit_st, hit_err;
  assign hit_ram = (Mem_WrAddr[31:AW+2] == '0);
  assign hit_led = (addr_w == BASE_W);
  assign hit_cyc = (addr_w == BASE_W + 32'd4);
  assign hit_st  = (addr_w == BASE_W + 32'd8);
  assign hit_err = (addr_w == BASE_W + 32'd12);

  logic [AW-1:0] ram_idx;
  assign ram_idx = Mem_WrAddr[AW+1:2];

  // STCNT is read-only, so a store to it is handled like any other store to
  // an unmapped address.
  logic store_ok, store_bad;
  assign store_ok  = MemWrite & (hit_ram | hit_led | hit_cyc | hit_err);
  assign store_bad = MemWrite & ~(hit_ram | hit_led | hit_cyc | hit_err);

  // RAM storage. It is deliberately not reset, so its contents survive a
  // reset. A store presented while reset is asserted is dropped.
  logic [31:0] ram_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (reset && MemWrite && hit_ram) begin
      ram_mem[ram_idx] <= Mem_WrData;
    end
  end

  // MMIO registers
  logic [7:0]  led_q,    led_d;
  logic [31:0] cyccnt_q, cyccnt_d;
  logic [31:0] stcnt_q,  stcnt_d;
  logic        err_q,    err_d;

  always_comb begin
    led_d    = led_q;
    cyccnt_d = cyccnt_q + 32'd1;
    stcnt_d  = stcnt_q;
    err_d    = err_q;

    if (MemWrite && hit_led) begin
      led_d = Mem_WrData[7:0];
    end

    // A store to CYCCNT zeroes the counter; it overrides the increment.
    if (MemWrite && hit_cyc) begin
      cyccnt_d = '0;
    end

    // Saturating store counter.
    if (store_ok && (stcnt_q != 32'hFFFF_FFFF)) begin
      stcnt_d = stcnt_q + 32'd1;
    end

    if (store_bad) begin
      err_d = 1'b1;
    end else if (MemWrite && hit_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q    <= '0;
      cyccnt_q <= '0;
      stcnt_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cyccnt_q <= cyccnt_d;
      stcnt_q  <= stcnt_d;
      err_q    <= err_d;
    end
  end

  // Zero-latency load path. It ignores MemWrite, so a load in a store cycle
  // returns the value held before the store.
  always_comb begin
    ReadData = '0;
    if (hit_ram) begin
      ReadData = ram_mem[ram_idx];
    end else if (hit_led) begin
      ReadData = {24'b0, led_q};
    end else if (hit_cyc) begin
      ReadData = cyccnt_q;
    end else if (hit_st) begin
      ReadData = stcnt_q;
    end else if (hit_err) begin
      ReadData = {31'b0, err_q};
    end
  end

  assign leds = led_q;
  assign err  = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed testbench for data_mem_resp.
// Inputs are driven just after the falling edge. Outputs are sampled 1 ns
// later, which is well away from the rising edge.

module tb_data_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  leds;
  logic        err;

  int chk_cnt;
  int pass_cnt;

  data_mem_resp #(
    .RAM_WORDS (64),
    .MMIO_BASE (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .MemWrite   (we),
    .Mem_WrAddr (addr),
    .Mem_WrData (wdata),
    .ReadData   (rdata),
    .leds       (leds),
    .err        (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s: got %h", tag, got);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Load: present the address, let the combinational path settle, compare.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  // Present one store for the current cycle.
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    $display("store addr=%h data=%h rst_n=%0b", a, d, rst_n);
  endtask

  // Advance one cycle and drop any store strobe.
  task automatic nxt();
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;

    repeat (2) @(negedge clk);

    // Reset state
    #1;
    check_eq("rst_leds", {24'b0, leds}, 32'h0);
    check_eq("rst_err", {31'b0, err}, 32'h0);
    rd("rst_cyccnt", 32'h104, 32'h0);
    rd("rst_stcnt", 32'h108, 32'h0);
    rd("rst_errstat", 32'h10C, 32'h0);

    // First cycle after reset reads 0, the next reads 1
    rst_n = 1'b1;
    rd("cyc_first", 32'h104, 32'h0);
    nxt();
    rd("cyc_second", 32'h104, 32'h1);

    // LED store
    st(32'h100, 32'h0000_01A5);
    nxt();
    #1;
    check_eq("led_out", {24'b0, leds}, 32'h0000_00A5);
    rd("led_load", 32'h100, 32'h0000_00A5);
    rd("stcnt_1", 32'h108, 32'h1);

    // RAM store: the same-cycle load returns the old value
    st(32'h04, 32'h1111_1111);
    nxt();
    st(32'h04, 32'hDEAD_BEEF);
    rd("ram_old", 32'h04, 32'h1111_1111);
    nxt();
    rd("ram_new", 32'h04, 32'hDEAD_BEEF);
    rd("ram_lsb_ign", 32'h07, 32'hDEAD_BEEF);
    rd("stcnt_3", 32'h108, 32'h3);

    // Top RAM word, and an address just past the mapped space
    st(32'hFC, 32'hCAFE_F00D);
    nxt();
    rd("ram_top", 32'hFC, 32'hCAFE_F00D);
    rd("ld_1fc", 32'h1FC, 32'h0);

    // Unmapped store sets err without counting
    st(32'h200, 32'h1234_5678);
    nxt();
    #1;
    check_eq("err_set", {31'b0, err}, 32'h1);
    rd("stcnt_unch", 32'h108, 32'h4);
    rd("ld_200", 32'h200, 32'h0);
    rd("errstat_1", 32'h10C, 32'h1);

    // ERRSTAT store clears err, whatever the data
    st(32'h10C, 32'hFFFF_FFFF);
    nxt();
    #1;
    check_eq("err_clr", {31'b0, err}, 32'h0);
    rd("stcnt_5", 32'h108, 32'h5);

    // A load from an unmapped address leaves err clear
    rd("ld_300", 32'h300, 32'h0);
    nxt();
    #1;
    check_eq("ld_no_err", {31'b0, err}, 32'h0);

    // A store to STCNT is an unmapped store
    st(32'h108, 32'h5);
    nxt();
    #1;
    check_eq("st_stcnt_err", {31'b0, err}, 32'h1);
    rd("stcnt_ro", 32'h108, 32'h5);

    // An out-of-range store must not alias onto RAM word 1
    st(32'h204, 32'h0);
    nxt();
    rd("no_alias", 32'h04, 32'hDEAD_BEEF);
    st(32'h10C, 32'h0);
    nxt();
    rd("stcnt_6", 32'h108, 32'h6);

    // Set err, then reset while stores are presented
    st(32'h200, 32'h0);
    nxt();
    rst_n = 1'b0;
    st(32'h100, 32'h0000_00FF);
    nxt();
    st(32'h04, 32'h0);
    nxt();
    rst_n = 1'b1;
    #1;
    check_eq("rst2_leds", {24'b0, leds}, 32'h0);
    check_eq("rst2_err", {31'b0, err}, 32'h0);
    rd("rst2_stcnt", 32'h108, 32'h0);
    rd("rst2_ram", 32'h04, 32'hDEAD_BEEF);
    rd("rst2_cyc0", 32'h104, 32'h0);

    // Ten idle cycles
    repeat (10) nxt();
    rd("cyc_10", 32'h104, 32'd10);

    // A CYCCNT store zeroes the counter at the edge
    st(32'h104, 32'h0000_ABCD);
    rd("cyc_st_cycle", 32'h104, 32'd10);
    nxt();
    rd("cyc_zeroed", 32'h104, 32'h0);
    nxt();
    rd("cyc_after0", 32'h104, 32'h1);

    // CYCCNT wrap
    force dut.cyccnt_q = 32'hFFFF_FFFF;
    rd("cyc_max", 32'h104, 32'hFFFF_FFFF);
    release dut.cyccnt_q;
    nxt();
    rd("cyc_wrap", 32'h104, 32'h0);

    // STCNT saturation
    force dut.stcnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stcnt_q;
    for (int i = 0; i < 3; i++) begin
      st(32'h08, 32'(i));
      nxt();
      rd($sformatf("stcnt_sat%0d", i), 32'h108, 32'hFFFF_FFFF);
    end
    rd("ram_08", 32'h08, 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Safety timeout
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 32-bit RAM words; power of two, 16..1024.
REQ-002 Parameter MMIO_BASE, default 32'h0000_0100, byte address of the first MMIO register; SHALL be >= 4*RAM_WORDS.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-005 Port MemWrite  input  1  CPU store strobe; one store per asserted cycle.
REQ-006 Port Mem_WrAddr  input  32  CPU byte address for loads and stores.
REQ-007 Port Mem_WrData  input  32  CPU store data.
REQ-008 Port ReadData  output  32  load data returned to the CPU.
REQ-009 Port leds  output  8  LED register value.
REQ-010 Port err  output  1  sticky unmapped-store flag.

Function
REQ-011 The block SHALL be the data-port responder for the single-cycle CPU: word-only accesses, address bits [1:0] ignored everywhere.
REQ-012 The address map SHALL be: RAM at [0, 4*RAM_WORDS); LED at MMIO_BASE+0 (RW, bits[7:0]); CYCCNT at +4 (RW); STCNT at +8 (RO); ERRSTAT at +C (RW); all other addresses unmapped.
REQ-013 ReadData SHALL be combinational from Mem_WrAddr and current state (zero-latency load), independent of MemWrite.
REQ-014 A store SHALL take effect at the rising edge of the cycle where MemWrite=1; a load of the same address in that cycle SHALL return the old value, and from the next cycle the new value.
REQ-015 RAM store: word[addr[log2(RAM_WORDS)+1:2]] <= Mem_WrData.
REQ-016 LED store: led_reg <= Mem_WrData[7:0]; leds = led_reg; LED load returns {24'b0, led_reg}.
REQ-017 CYCCNT: 32-bit free-running counter, +1 every non-reset cycle, wraps 32'hFFFF_FFFF -> 0.
REQ-018 A store to CYCCNT SHALL load 0 at that edge regardless of data (store beats increment); the following cycle reads 0.
REQ-019 STCNT SHALL increment on each accepted store (RAM, LED, CYCCNT, ERRSTAT); it SHALL saturate at 32'hFFFF_FFFF; stores to STCNT address are ignored and not counted.
REQ-020 A store to an unmapped address (including STCNT) SHALL modify no storage and set err <= 1.
REQ-021 A store to ERRSTAT SHALL clear err <= 0 regardless of data; ERRSTAT load returns {31'b0, err}.
REQ-022 Loads from unmapped addresses SHALL return 32'h0000_0000 and SHALL NOT set err.
REQ-023 Addresses >= 4*RAM_WORDS SHALL never alias into RAM.

Reset
REQ-024 While reset=0 at a rising edge: led_reg, CYCCNT, STCNT, err SHALL become 0; any store that cycle is discarded.
REQ-025 RAM contents SHALL NOT be affected by reset and SHALL be retained across it; RAM is undefined until first written.
REQ-026 In the first cycle after reset deasserts, CYCCNT reads 0; it reads 1 one cycle later.

Verification
REQ-027 Store 32'hDEAD_BEEF to 0x04, then load 0x04 same cycle -> old value; next cycle -> 32'hDEAD_BEEF; load 0x07 -> 32'hDEAD_BEEF.
REQ-028 Store 32'h0000_01A5 to 0x100 -> leds=8'hA5, load 0x100 = 32'h0000_00A5, STCNT=1.
REQ-029 Reset then idle 10 cycles -> CYCCNT load = 10; store to 0x104 -> next cycle 0, then 1; force CYCCNT 32'hFFFF_FFFF -> wraps to 0.
REQ-030 Store to 0x200 -> err=1, STCNT unchanged, load 0x200 = 0; store to 0x10C -> err=0.
REQ-031 Assert reset=0 in a cycle with MemWrite=1 to 0x100 -> leds=0, STCNT=0, RAM word 0x04 still 32'hDEAD_BEEF.
REQ-032 Preload STCNT to 32'hFFFF_FFFE, issue 3 stores -> STCNT = 32'hFFFF_FFFF, no wrap.
